// File: rtl/fir_tap_loader.sv
// fir_tap_loader
//
// Loads the coefficient sets of a two-stage decimation FIR chain from one
// shared coefficient BROM. A single address counter walks the concatenated
// tap table: stage 0 taps first, then stage 1 taps. Each returned word is
// steered to the tap-write strobe of the stage it belongs to.
//
// Optional feature: define FIR_TAP_LOADER_CHECK_EN to enable the sticky
// BROM handshake checker that drives err. Without it, err is tied low.
//
// Ports:
//   clk             sole clock
//   reset           synchronous, active-high
//   enable          low behaves as reset
//   reload          one-cycle request to reload both stages (honoured in DONE only)
//   rom_addr        BROM address
//   rom_addr_valid  BROM read strobe
//   rom_data        BROM read data (signed coefficient)
//   rom_data_valid  BROM data strobe, one cycle after rom_addr_valid
//   tap_val         coefficient presented to both FIRs
//   tap_wr          per-stage tap write strobe (bit0 stage 0, bit1 stage 1)
//   fir_flush       one-cycle pulse before each load, resets FIR write pointers
//   taps_loaded     both stages hold a complete coefficient set
//   busy            load in progress (FLUSH, ISSUE, DRAIN)
//   err             sticky BROM handshake error
module fir_tap_loader #(
  parameter int G_TAP_RES = 16,
  parameter int G_TAPS_S0 = 63,
  parameter int G_TAPS_S1 = 31,
  parameter int G_ADDR_W  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 reload,
  output logic [G_ADDR_W-1:0]  rom_addr,
  output logic                 rom_addr_valid,
  input  logic [G_TAP_RES-1:0] rom_data,
  input  logic                 rom_data_valid,
  output logic [G_TAP_RES-1:0] tap_val,
  output logic [1:0]           tap_wr,
  output logic                 fir_flush,
  output logic                 taps_loaded,
  output logic                 busy,
  output logic                 err
);

  // First stage-1 address and the last table address.
  localparam logic [G_ADDR_W-1:0] ADDR_S1   = G_ADDR_W'(G_TAPS_S0);
  localparam logic [G_ADDR_W-1:0] ADDR_LAST = G_ADDR_W'(G_TAPS_S0 + G_TAPS_S1 - 1);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [G_ADDR_W-1:0] addr_reg, addr_next;
  // Stage tag of the read issued last cycle; lines up with rom_data_valid.
  logic                tag_reg, tag_next;
  logic                active;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      tag_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      tag_reg   <= tag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    tag_next   = tag_reg;
    case (state_reg)
      IDLE: begin
        // Reaching here means reset is low and enable is high: load at once.
        state_next = FLUSH;
        addr_next  = '0;
      end
      FLUSH: begin
        state_next = ISSUE;
        addr_next  = '0;
      end
      ISSUE: begin
        tag_next = (addr_reg >= ADDR_S1);
        // Counter holds at the last address instead of wrapping.
        if (addr_reg == ADDR_LAST) begin
          state_next = DRAIN;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        if (reload) begin
          state_next = FLUSH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign active         = (state_reg != IDLE);
  assign rom_addr_valid = (state_reg == ISSUE);
  assign rom_addr       = rom_addr_valid ? addr_reg : '0;
  assign fir_flush      = (state_reg == FLUSH);
  assign taps_loaded    = (state_reg == DONE);
  assign busy           = (state_reg == FLUSH) || (state_reg == ISSUE) || (state_reg == DRAIN);
  // Data still in flight when the loader is forced idle is dropped.
  assign tap_val        = active ? rom_data : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_tap_wr
      assign tap_wr[gi] = rom_data_valid && active && (tag_reg == 1'(gi));
    end
  endgenerate

`ifdef FIR_TAP_LOADER_CHECK_EN
  logic issued_reg;
  logic err_reg;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      issued_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      issued_reg <= rom_addr_valid;
      // The idle cycle after a forced stop may still see a late data strobe;
      // that word is discarded and is not a protocol violation.
      if (active && (rom_data_valid != issued_reg)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/fir_tap_loader.md
# fir_tap_loader

Sequencer that loads coefficient sets for a two-stage decimation filter chain (63-tap 4x stage, 31-tap 2x stage) from one shared coefficient BROM. It replaces the free-running per-stage BROM address counters. It walks a single concatenated tap table, steers each returned coefficient to the correct `tiny_fir` tap-write port, and reports when both stages are loaded. It also supports runtime reload of the coefficients without resetting the datapath.

## Interface

Parameters:
- `G_TAP_RES`, 16, coefficient width in bits
- `G_TAPS_S0`, 63, tap count of stage 0 (4x FIR); table addresses 0 .. G_TAPS_S0-1
- `G_TAPS_S1`, 31, tap count of stage 1 (2x FIR); table addresses G_TAPS_S0 .. G_TAPS_S0+G_TAPS_S1-1
- `G_ADDR_W`, 7, BROM address width; must hold G_TAPS_S0+G_TAPS_S1-1

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  low behaves as reset (all state cleared)
- `reload`  in  1  one-cycle request to reload both stages
- `rom_addr`  out  G_ADDR_W  BROM address
- `rom_addr_valid`  out  1  BROM read strobe
- `rom_data`  in  G_TAP_RES  BROM data, signed
- `rom_data_valid`  in  1  BROM data strobe, exactly 1 cycle after `rom_addr_valid`
- `tap_val`  out  G_TAP_RES  coefficient to both FIRs (= `rom_data`, combinational)
- `tap_wr`  out  2  per-stage tap write; bit0 stage 0, bit1 stage 1
- `fir_flush`  out  1  one-cycle pulse before each load; resets FIR tap-write pointers
- `taps_loaded`  out  1  high when both stages hold a complete set
- `busy`  out  1  high in FLUSH, ISSUE and DRAIN
- `err`  out  1  sticky protocol error (see Configuration)

## Operation

- FSM states: IDLE, FLUSH, ISSUE, DRAIN, DONE.
- `reset`=1 or `enable`=0 forces IDLE. All outputs are 0 at that point; address counter and stage tag are cleared.
- IDLE → FLUSH on the first edge with `reset`=0 and `enable`=1. Loading starts automatically; no `reload` is needed.
- FLUSH lasts 1 cycle:
  - `fir_flush`=1, `taps_loaded`=0
  - next state ISSUE, address counter = 0
- ISSUE:
  - `rom_addr_valid`=1 and `rom_addr`=counter every cycle.
  - Counter increments by 1 per cycle.
  - Stage tag = 0 while counter < G_TAPS_S0, else 1. The tag is registered alongside the issue, giving 1 cycle of alignment with `rom_data_valid`.
  - After address G_TAPS_S0+G_TAPS_S1-1 is issued, next state is DRAIN.
- DRAIN lasts 1 cycle and waits for the final `rom_data_valid`; next state DONE.
- DONE:
  - `taps_loaded`=1, `busy`=0.
  - `reload`=1 → FLUSH, and `taps_loaded` drops in that same transition.
- `tap_wr[s]` = `rom_data_valid` AND (registered tag == s). Exactly one bit is high per returned word.
- `reload` in any state other than DONE is ignored (not queued).
- No backpressure. The FIRs accept one tap write per cycle.
- Counter never wraps. It stops at the last address.

## Timing

- Edge E0: first edge with `enable`=1 and `reset`=0. FLUSH is entered after E0, so `fir_flush` is high in cycle 1.
- Cycles 2 .. 95: `rom_addr_valid` high, addresses 0..93.
- Cycles 3 .. 96: `rom_data_valid` returns.
  - `tap_wr[0]` high in cycles 3..65 (63 writes).
  - `tap_wr[1]` high in cycles 66..96 (31 writes).
- Cycle 97 onward: `taps_loaded`=1. Full load latency from entering FLUSH to `taps_loaded` is 96 cycles with defaults.
- Reload: `reload` sampled in DONE at edge Er. `fir_flush` is high the cycle after Er and `taps_loaded` is 0 in that same cycle. The sequence then repeats the 96-cycle pattern.
- Reset or `enable` drop mid-load:
  - Outputs go to 0 on the next edge.
  - In-flight `rom_data_valid` is discarded: `tap_wr` is gated by a state ≠ IDLE check.
  - A fresh load starts from FLUSH when re-enabled.

## Configuration

- `FIR_TAP_LOADER_CHECK_EN` defined:
  - `err` sets when `rom_data_valid`=1 in a cycle where no read was issued on the previous cycle, or when `rom_data_valid`=0 in a cycle where one was issued.
  - `err` is cleared only by `reset` or `enable`=0.
  - Loading continues regardless of `err`.
- Macro undefined: `err` is tied to 0 and the check logic is absent.

## Test plan

- Power-up load with a 1-cycle BROM model, data = address+100:
  - 63 `tap_wr[0]` writes of values 100..162, then 31 `tap_wr[1]` writes of values 163..193.
  - `taps_loaded` rises on cycle 97; `fir_flush` is seen exactly once.
- `reload` pulse in DONE: `taps_loaded` drops the next cycle, one `fir_flush` pulse, the identical 94-write sequence, then `taps_loaded` high again.
- `reload` held high at address 40 during ISSUE: no restart, single `fir_flush`, counts of 63 and 31 writes unchanged.
- `enable` dropped at address 70, restored 5 cycles later:
  - no `tap_wr` while disabled;
  - the new load begins with `fir_flush` and address 0;
  - totals are 63 and 31.
- `reset` asserted in DONE: all outputs 0 next cycle; after release, auto-load completes in 96 cycles.
- With `FIR_TAP_LOADER_CHECK_EN`:
  - Inject a spurious `rom_data_valid` in DONE: `err`=1 and stays 1 until `reset`.
  - Without the macro, the same stimulus leaves `err`=0.
